// File: rtl/condlogic_banked.sv
`default_nettype none
// ============================================================================
// Module   : condlogic_banked
// Purpose  : Banked NZCV condition evaluation with a predication window.
// Revision : 1.0 - initial release
// ============================================================================
module condlogic_banked #(
  parameter int NBANK = 2,
  parameter int ITMAX = 4,
  localparam int BW = $clog2(NBANK),
  localparam int CW = $clog2(ITMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic [BW-1:0] Bank,
  input  logic          Latch,
  input  logic          PCS,
  input  logic          NextPC,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          ITLoad,
  input  logic [CW-1:0] ITCount,
  input  logic [3:0]    ITCond,
  output logic          PCWrite,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          CondExR,
  output logic          ITActive,
  output logic [3:0]    Flags
);

  localparam logic [CW-1:0] C_ITMAX = CW'(ITMAX);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    itc_q, itc_d;
  logic          condexr_q;
  logic [3:0]    flags_q [NBANK];

  logic [3:0]    w_sel;
  logic [3:0]    w_eff_cond;
  logic          w_condex;
  logic [CW-1:0] w_count_sat;
  logic          w_n, w_z, w_c, w_v;

  // Out-of-range bank indices (non power-of-two NBANK) read as zero flags.
  always_comb begin
    w_sel = 4'b0000;
    if ({1'b0, Bank} < (BW+1)'(NBANK)) w_sel = flags_q[Bank];
  end

  assign {w_n, w_z, w_c, w_v} = w_sel;
  assign w_eff_cond = (state_q == RUN) ? itc_q : Cond;

  always_comb begin
    w_condex = 1'b0;
    case (w_eff_cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_count_sat = (ITCount > C_ITMAX) ? C_ITMAX : ITCount;

  // A reload takes priority over the Latch decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    itc_d   = itc_q;
    case (state_q)
      IDLE: begin
        if (ITLoad && (ITCount != '0)) begin
          state_d = RUN;
          cnt_d   = w_count_sat;
          itc_d   = ITCond;
        end
      end
      RUN: begin
        if (ITLoad) begin
          if (ITCount != '0) begin
            cnt_d = w_count_sat;
            itc_d = ITCond;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (Latch) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      itc_q     <= 4'b0000;
      condexr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      itc_q   <= itc_d;
      if (Latch) condexr_q <= w_condex;
    end
  end

  // Flag write-back is gated by the previously latched condition result.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (reset) begin
        flags_q[b] <= 4'b0000;
      end else if (condexr_q && ({1'b0, Bank} == (BW+1)'(b))) begin
        if (FlagW[1]) flags_q[b][3:2] <= ALUFlags[3:2];
        if (FlagW[0]) flags_q[b][1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign CondExR  = condexr_q;
  assign PCWrite  = NextPC | (PCS & condexr_q);
  assign RegWrite = RegW & condexr_q;
  assign MemWrite = MemW & condexr_q;
  assign ITActive = (state_q == RUN);
  assign Flags    = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_condlogic_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_condlogic_banked
// Purpose  : Directed self-checking bench for condlogic_banked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_condlogic_banked;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, ITCond;
  logic [1:0] FlagW;
  logic [0:0] Bank;
  logic       Latch, PCS, NextPC, RegW, MemW, ITLoad;
  logic [2:0] ITCount;
  logic       PCWrite, RegWrite, MemWrite, CondExR, ITActive;
  logic [3:0] Flags;

  int checks = 0;
  int failures = 0;

  condlogic_banked #(.NBANK(2), .ITMAX(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .Bank(Bank), .Latch(Latch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .ITLoad(ITLoad), .ITCount(ITCount), .ITCond(ITCond),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondExR(CondExR), .ITActive(ITActive), .Flags(Flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ARM condition table written from the instruction-set definition.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:  return z;          4'd1:  return !z;
      4'd2:  return cc;         4'd3:  return !cc;
      4'd4:  return n;          4'd5:  return !n;
      4'd6:  return v;          4'd7:  return !v;
      4'd8:  return cc && !z;   4'd9:  return !cc || z;
      4'd10: return n == v;     4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [3:0] c);
    Cond = c; Latch = 1'b1;
    tick();
    Latch = 1'b0;
  endtask

  task automatic set_flags(input logic b, input logic [3:0] f);
    Bank = b; FlagW = 2'b00;
    latch(4'b1110);
    FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b0; ALUFlags = 4'b0; ITCond = 4'b0; FlagW = 2'b0;
    Bank = 1'b0; Latch = 1'b0; PCS = 1'b1; NextPC = 1'b0; RegW = 1'b1;
    MemW = 1'b1; ITLoad = 1'b0; ITCount = 3'd0;
    tick(); tick();

    chk("rst_condexr", {7'b0, CondExR}, 8'h0);
    chk("rst_itactive", {7'b0, ITActive}, 8'h0);
    chk("rst_flags", {4'b0, Flags}, 8'h0);
    chk("rst_regwrite", {7'b0, RegWrite}, 8'h0);
    chk("rst_memwrite", {7'b0, MemWrite}, 8'h0);
    chk("rst_pcwrite0", {7'b0, PCWrite}, 8'h0);
    NextPC = 1'b1; #1;
    chk("rst_pcwrite1", {7'b0, PCWrite}, 8'h1);
    NextPC = 1'b0; PCS = 1'b0;
    reset = 1'b0;
    tick();

    // Bank isolation
    set_flags(1'b1, 4'b0100);
    chk("bank1_flags", {4'b0, Flags}, 8'h4);
    Bank = 1'b0; #1;
    chk("bank0_flags", {4'b0, Flags}, 8'h0);
    Bank = 1'b1; latch(4'b0000);
    chk("iso_b1_condexr", {7'b0, CondExR}, 8'h1);
    chk("iso_b1_regwrite", {7'b0, RegWrite}, 8'h1);
    chk("iso_b1_memwrite", {7'b0, MemWrite}, 8'h1);
    Bank = 1'b0; latch(4'b0000);
    chk("iso_b0_condexr", {7'b0, CondExR}, 8'h0);
    chk("iso_b0_regwrite", {7'b0, RegWrite}, 8'h0);

    // Full condition sweep on bank 0
    for (int f = 0; f < 16; f++) begin
      set_flags(1'b0, 4'(f));
      chk($sformatf("sweep_flags_%0h", f), {4'b0, Flags}, 8'(f));
      for (int c = 0; c < 16; c++) begin
        latch(4'(c));
        chk($sformatf("sweep_f%0h_c%0h", f, c), {7'b0, CondExR},
            {7'b0, ref_cond(4'(c), 4'(f))});
      end
    end

    // Partial flag write
    set_flags(1'b0, 4'b1111);
    latch(4'b1110);
    FlagW = 2'b10; ALUFlags = 4'b0000; tick(); FlagW = 2'b00;
    chk("partial_nz", {4'b0, Flags}, 8'h3);
    latch(4'b0000);
    chk("partial_fail_condexr", {7'b0, CondExR}, 8'h0);
    FlagW = 2'b11; ALUFlags = 4'b1111; tick(); FlagW = 2'b00;
    chk("partial_fail_hold", {4'b0, Flags}, 8'h3);

    // PC write gating
    NextPC = 1'b1; PCS = 1'b0; #1;
    chk("pc_nextpc", {7'b0, PCWrite}, 8'h1);
    NextPC = 1'b0; PCS = 1'b1; #1;
    chk("pc_pcs_fail", {7'b0, PCWrite}, 8'h0);
    latch(4'b1110);
    chk("pc_pcs_pass", {7'b0, PCWrite}, 8'h1);
    PCS = 1'b0;

    // No bypass: evaluation uses bank contents before the edge
    set_flags(1'b0, 4'b0100);
    FlagW = 2'b11; ALUFlags = 4'b0000;
    latch(4'b0000);
    FlagW = 2'b00;
    chk("nobypass_condexr", {7'b0, CondExR}, 8'h1);
    chk("nobypass_flags", {4'b0, Flags}, 8'h0);

    // Predication window, length 2, NE with Z=1
    set_flags(1'b0, 4'b0100);
    ITLoad = 1'b1; ITCount = 3'd2; ITCond = 4'b0001; tick(); ITLoad = 1'b0;
    chk("win_active_load", {7'b0, ITActive}, 8'h1);
    latch(4'b1110);
    chk("win_l1_condexr", {7'b0, CondExR}, 8'h0);
    chk("win_l1_active", {7'b0, ITActive}, 8'h1);
    latch(4'b1110);
    chk("win_l2_condexr", {7'b0, CondExR}, 8'h0);
    chk("win_l2_active", {7'b0, ITActive}, 8'h0);
    latch(4'b1110);
    chk("win_l3_condexr", {7'b0, CondExR}, 8'h1);

    // ITLoad with zero count in IDLE is ignored
    ITLoad = 1'b1; ITCount = 3'd0; ITCond = 4'b0001; tick(); ITLoad = 1'b0;
    chk("zero_load_active", {7'b0, ITActive}, 8'h0);
    latch(4'b1110);
    chk("zero_load_condexr", {7'b0, CondExR}, 8'h1);

    // ITCount above ITMAX saturates to 4
    ITLoad = 1'b1; ITCount = 3'd7; ITCond = 4'b0001; tick(); ITLoad = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      latch(4'b1110);
      chk($sformatf("sat_l%0d_condexr", i), {7'b0, CondExR}, 8'h0);
      chk($sformatf("sat_l%0d_active", i), {7'b0, ITActive}, (i < 4) ? 8'h1 : 8'h0);
    end
    latch(4'b1110);
    chk("sat_l5_condexr", {7'b0, CondExR}, 8'h1);

    // ITLoad and Latch together: first instruction uses Cond
    ITLoad = 1'b1; ITCount = 3'd1; ITCond = 4'b0001;
    latch(4'b0000);
    ITLoad = 1'b0;
    chk("same_cyc_condexr", {7'b0, CondExR}, 8'h1);
    chk("same_cyc_active", {7'b0, ITActive}, 8'h1);
    latch(4'b1110);
    chk("same_cyc_next_condexr", {7'b0, CondExR}, 8'h0);
    chk("same_cyc_next_active", {7'b0, ITActive}, 8'h0);

    // ITLoad with zero count in RUN ends the window
    ITLoad = 1'b1; ITCount = 3'd2; ITCond = 4'b0001; tick();
    chk("run_zero_pre", {7'b0, ITActive}, 8'h1);
    ITCount = 3'd0; tick(); ITLoad = 1'b0;
    chk("run_zero_active", {7'b0, ITActive}, 8'h0);

    // Reset mid-window
    latch(4'b1110);
    ITLoad = 1'b1; ITCount = 3'd3; ITCond = 4'b0001; tick(); ITLoad = 1'b0;
    chk("rstmid_pre_active", {7'b0, ITActive}, 8'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstmid_active", {7'b0, ITActive}, 8'h0);
    chk("rstmid_flags", {4'b0, Flags}, 8'h0);
    chk("rstmid_condexr", {7'b0, CondExR}, 8'h0);
    Bank = 1'b1; #1;
    chk("rstmid_bank1", {4'b0, Flags}, 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/condlogic_banked.md
# condlogic_banked

Parametrised conditional-execution unit for the multicycle ARM datapath, successor to the single-bank condition logic. It holds NBANK independent NZCV flag banks, evaluates ARM condition codes against a selected bank, and registers the result once per instruction for use in later cycles. It also runs a predication window in which a fixed condition overrides the instruction's own Cond field for a programmed number of instructions. It sits between the main decoder/FSM and the register file, memory and PC write enables.

## Interface

Parameters:
- NBANK, 2, number of flag banks; must be at least 2. BW = $clog2(NBANK).
- ITMAX, 4, maximum predication window length; must be at least 1. CW = $clog2(ITMAX+1).

Ports:
- clk  in  1  system clock; single clock domain, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  condition field of the current instruction.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- Bank  in  BW  flag bank used for evaluation and write-back.
- Latch  in  1  decode-cycle strobe; captures CondEx into CondExR.
- PCS, NextPC, RegW, MemW  in  1 each  raw write requests from the decoder/FSM.
- ITLoad  in  1  starts a predication window.
- ITCount  in  CW  window length for ITLoad.
- ITCond  in  4  override condition for the window.
- PCWrite, RegWrite, MemWrite  out  1 each  gated write enables.
- CondExR  out  1  registered condition result of the current instruction.
- ITActive  out  1  high while the unit is in state RUN.
- Flags  out  4  the bank currently selected by Bank.

## Operation

- **State:**
  - Flags[NBANK] are 4-bit registers.
  - CondExR is a 1-bit register.
  - The FSM has two states, IDLE and RUN.
  - The down-counter Cnt is CW bits wide; the override register ITC is 4 bits wide.
- **Effective condition:** EffCond = ITC when in RUN, otherwise Cond.
- **CondEx (combinational)** is evaluated from EffCond against bank[Bank], named N,Z,C,V:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111: 0 (never)
- **CondExR:** loads CondEx when Latch=1, otherwise holds.
- **Output gating:**
  - PCWrite = NextPC | (PCS & CondExR)
  - RegWrite = RegW & CondExR
  - MemWrite = MemW & CondExR
- **Flag write:**
  - If FlagW[1] & CondExR: bank[Bank][3:2] <= ALUFlags[3:2].
  - If FlagW[0] & CondExR: bank[Bank][1:0] <= ALUFlags[1:0].
  - All other banks are never written.
- **FSM:**
  - IDLE, on ITLoad with ITCount != 0: go to RUN, Cnt <= ITCount, ITC <= ITCond.
  - IDLE, on ITLoad with ITCount == 0: ignored.
  - RUN, on Latch: Cnt <= Cnt-1. If Cnt == 1, go to IDLE.
  - RUN, on ITLoad with ITCount != 0: reload Cnt and ITC and stay in RUN; this takes priority over the Latch decrement.
  - RUN, on ITLoad with ITCount == 0: go to IDLE.
- **Range:** ITCount > ITMAX is saturated to ITMAX.

## Timing

- **Reset values:**
  - All flag banks 0000.
  - CondExR = 0, so RegWrite = 0 and MemWrite = 0.
  - PCWrite equals NextPC (combinational only).
  - State IDLE, Cnt = 0, ITC = 0000, ITActive = 0.
  - Flags output reads 0000.
- **Latency:** Cond or Bank to CondEx is combinational. CondEx reaches CondExR, and therefore the write enables, one cycle after Latch.
- **No bypass:** the evaluation in a Latch cycle uses bank contents from before that edge, even if a flag write hits the same bank in the same cycle.
- **Window boundary:** a Latch in the same cycle as ITLoad evaluates with the pre-load mode (Cond in IDLE, old ITC in RUN). The new window governs the next Latch onward.
- **Window end:** the Latch that decrements Cnt from 1 is the last one evaluated with ITC. ITActive falls in the following cycle.
- **Reset mid-window:** a synchronous reset mid-window returns the unit to IDLE and clears all state on that edge.
- **Idle outputs:** PCWrite, RegWrite and MemWrite are combinational in NextPC, PCS, RegW, MemW and CondExR.

## Test plan

- **Bank isolation:** Write bank1 with 0100 (Z=1) using Latch+AL and FlagW=11; leave bank0 at 0000. Evaluate Cond=0000 (EQ).
  - Bank=1: CondExR=1 after Latch and RegWrite follows RegW.
  - Bank=0: CondExR=0 and RegWrite=0.
- **Full condition sweep:** For each of the 16 NZCV values × 16 Cond codes, CondExR must match the table. Cond=1111 always gives 0.
- **Partial flag write:** Set bank0=1111, then a condition-passing op with FlagW=10 and ALUFlags=0000.
  - Bank0 becomes 0011.
  - With a failing condition (CondExR=0), bank0 is unchanged.
- **Predication window:** ITLoad with ITCount=2, ITCond=0001 (NE), Z=1, then three Latches with Cond=1110 (AL).
  - CondExR sequence: 0, 0, 1.
  - ITActive is high for exactly the two Latch-bounded intervals.
- **Edge cases:**
  - ITLoad with ITCount=0 in IDLE: no state change.
  - ITCount=7 with ITMAX=4: window length is 4.
  - ITLoad and Latch in the same cycle: the first instruction uses Cond.
  - Reset asserted mid-window: ITActive=0 next cycle and banks return to 0000.
- **PC write:** With NextPC=1 and CondExR=0, PCWrite=1. With PCS=1, NextPC=0 and CondExR=0, PCWrite=0.
